// File: rtl/io_stress_host.sv
// Host-side stress engine for a device FIFO loopback: streams an incrementing
// pattern out on tx, checks the returned rx stream against the same pattern.
module io_stress_host #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      num_words,
    input  logic             stall_en,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] first_err_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [31:0]      count_r;
    logic [31:0]      tx_cnt_r;
    logic [31:0]      rx_cnt_r;
    logic [2:0]       stall_cnt_r;
    logic             tx_valid_r;
    logic             rx_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             error_r;
    logic [15:0]      err_count_r;
    logic [WIDTH-1:0] first_err_r;

    logic             stall_next_s;
    logic             tx_fire_s;
    logic             rx_fire_s;
    logic             rx_mismatch_s;
    logic [31:0]      tx_cnt_nxt_s;
    logic [31:0]      rx_cnt_nxt_s;

    // Valid/ready are registered, so the stall decision is made one edge early:
    // the cycle after this one is a stall cycle when the counter now reads 6.
    assign stall_next_s  = stall_en && (stall_cnt_r == 3'd6);
    assign tx_fire_s     = tx_valid_r && tx_ready;
    assign rx_fire_s     = rx_ready_r && rx_valid;
    assign tx_cnt_nxt_s  = tx_cnt_r + {31'd0, tx_fire_s};
    assign rx_cnt_nxt_s  = rx_cnt_r + {31'd0, rx_fire_s};
    assign rx_mismatch_s = rx_fire_s && (rx_data != rx_cnt_r[WIDTH-1:0]);

    assign tx_data        = tx_cnt_r[WIDTH-1:0];
    assign tx_valid       = tx_valid_r;
    assign rx_ready       = rx_ready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;
    assign err_count      = err_count_r;
    assign first_err_data = first_err_r;

    // Run-control FSM with transfer counters, stall timing and rx error status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= 32'd0;
            tx_cnt_r    <= 32'd0;
            rx_cnt_r    <= 32'd0;
            stall_cnt_r <= 3'd0;
            tx_valid_r  <= 1'b0;
            rx_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            err_count_r <= 16'd0;
            first_err_r <= {WIDTH{1'b0}};
        end else begin
            stall_cnt_r <= stall_cnt_r + 3'd1;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        count_r     <= num_words;
                        tx_cnt_r    <= 32'd0;
                        rx_cnt_r    <= 32'd0;
                        error_r     <= 1'b0;
                        err_count_r <= 16'd0;
                        first_err_r <= {WIDTH{1'b0}};
                        if (num_words != 32'd0) begin
                            state_r    <= RUN;
                            busy_r     <= 1'b1;
                            done_r     <= 1'b0;
                            tx_valid_r <= !stall_next_s;
                            rx_ready_r <= !stall_next_s;
                        end else begin
                            state_r    <= DONE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b1;
                            tx_valid_r <= 1'b0;
                            rx_ready_r <= 1'b0;
                        end
                    end else begin
                        tx_valid_r <= 1'b0;
                        rx_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    tx_cnt_r <= tx_cnt_nxt_s;
                    rx_cnt_r <= rx_cnt_nxt_s;
                    if (rx_mismatch_s) begin
                        error_r <= 1'b1;
                        if (err_count_r != 16'hFFFF) begin
                            err_count_r <= err_count_r + 16'd1;
                        end
                        if (err_count_r == 16'd0) begin
                            first_err_r <= rx_data;
                        end
                    end
                    if ((tx_cnt_nxt_s == count_r) && (rx_cnt_nxt_s == count_r)) begin
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        tx_valid_r <= 1'b0;
                        rx_ready_r <= 1'b0;
                    end else begin
                        // A word already offered stays offered until taken, stall or not.
                        tx_valid_r <= (tx_valid_r && !tx_ready) ||
                                      ((tx_cnt_nxt_s < count_r) && !stall_next_s);
                        rx_ready_r <= (rx_cnt_nxt_s < count_r) && !stall_next_s;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                    rx_ready_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
